// File: rtl/conv_window_gen_pkg.sv
// Shared defaults and index helpers for the convolution window generator.
package cnn_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_K     = 3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flat element index of window cell (r,c); r=0 oldest row, c=0 oldest column.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle; master is the pixel source, slave the window generator.
interface conv_window_gen_if
  import cnn_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = DEF_K,
  parameter int WIDTH = DEF_WIDTH
);

  logic                          in_valid;
  logic [WIDTH-1:0]              in_data;
  logic                          win_valid;
  logic [K*K*WIDTH-1:0]          win_data;
  logic [cnt_w(IMG_H)-1:0]       win_row;
  logic [cnt_w(IMG_W)-1:0]       win_col;
  logic                          frame_done;

  modport master (
    output in_valid, in_data,
    input  win_valid, win_data, win_row, win_col, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output win_valid, win_data, win_row, win_col, frame_done
  );

endinterface

// File: rtl/conv_window_gen_line_delay.sv
// Enable-gated line delay: so is si delayed by DEPTH accepted beats; cleared by synchronous reset.
module win_line_delay
  import cnn_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] si,
  output logic [WIDTH-1:0] so
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (en) begin
      sr_q <= {sr_q[DEPTH-2:0], si};
    end
  end

  assign so = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// K x K sliding window over a row-major pixel stream; one-cycle registered latency, no backpressure.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = DEF_K,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  conv_window_gen_if.slave  bus
);

  localparam int RW = cnt_w(IMG_H);
  localparam int CW = cnt_w(IMG_W);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);

  logic                        accept;
  logic [RW-1:0]               row_q, row_d;
  logic [CW-1:0]               col_q, col_d;
  logic [K*K-1:0][WIDTH-1:0]   win_q, win_d;
  logic                        win_valid_q, win_valid_d;
  logic                        frame_done_q, frame_done_d;
  logic [RW-1:0]               win_row_q, win_row_d;
  logic [CW-1:0]               win_col_q, win_col_d;
  logic [WIDTH-1:0]            tap [K-1];

  assign accept = bus.in_valid;

  // tap[j] holds the pixel (j+1) rows above the one currently on in_data.
  for (genvar j = 0; j < K - 1; j++) begin : g_ld
    if (j == 0) begin : g_first
      win_line_delay #(.DEPTH(IMG_W), .WIDTH(WIDTH)) u_ld (
        .clk(clk), .rst_n(rst_n), .en(accept), .si(bus.in_data), .so(tap[j])
      );
    end else begin : g_chain
      win_line_delay #(.DEPTH(IMG_W), .WIDTH(WIDTH)) u_ld (
        .clk(clk), .rst_n(rst_n), .en(accept), .si(tap[j-1]), .so(tap[j])
      );
    end
  end

  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    if (accept) begin
      win_valid_d  = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
      frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      win_row_d    = row_q;
      win_col_d    = col_q;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[win_idx(r, c, K)] = win_q[win_idx(r, c + 1, K)];
        end
      end
      win_d[win_idx(K - 1, K - 1, K)] = bus.in_data;
      for (int j = 0; j < K - 1; j++) begin
        win_d[win_idx(K - 2 - j, K - 1, K)] = tap[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.win_data   = win_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed and random stimulus against an image-array reference model for conv_window_gen (4x4, K=3).
module tb_conv_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int KK = 3;
  localparam int PW = 4;

  localparam logic [35:0] S1_FIRST = {4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2, 4'd1, 4'd0};
  localparam logic [35:0] S1_LAST  = {4'd15, 4'd14, 4'd13, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5};
  localparam logic [35:0] F2_FIRST = {4'd13, 4'd12, 4'd11, 4'd9, 4'd8, 4'd7, 4'd5, 4'd4, 4'd3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_gen_if #(.IMG_W(W), .IMG_H(H), .K(KK), .WIDTH(PW)) bus ();

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .K(KK), .WIDTH(PW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current frame image plus the position of the next pixel.
  int          mr, mc;
  logic [3:0]  img [H][W];
  logic        exp_vld, exp_fd;
  logic [35:0] exp_win;
  int          exp_row, exp_col;
  int          nwin, nfd;
  logic [35:0] first_win, fd_win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    nwin = 0;
    nfd = 0;
    first_win = '0;
    fd_win = '0;
  endtask

  task automatic step(input logic v, input logic [3:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    if (v) begin
      img[mr][mc] = d;
      exp_vld = (mr >= KK - 1) && (mc >= KK - 1);
      exp_fd  = (mr == H - 1) && (mc == W - 1);
      exp_row = mr;
      exp_col = mc;
      exp_win = '0;
      if (exp_vld) begin
        for (int r = 0; r < KK; r++)
          for (int c = 0; c < KK; c++)
            exp_win[(r * KK + c) * PW +: PW] = img[mr - (KK - 1) + r][mc - (KK - 1) + c];
      end
      mc = mc + 1;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end else begin
      exp_vld = 1'b0;
      exp_fd  = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("win_valid", 64'(bus.win_valid), 64'(exp_vld));
    chk("frame_done", 64'(bus.frame_done), 64'(exp_fd));
    if (exp_vld) begin
      chk("win_data", 64'(bus.win_data), 64'(exp_win));
      chk("win_row", 64'(bus.win_row), 64'(exp_row));
      chk("win_col", 64'(bus.win_col), 64'(exp_col));
    end
    chk("inv_pos", 64'(bus.win_valid && (bus.win_row < 2'd2 || bus.win_col < 2'd2)), 64'(0));
    chk("inv_fd", 64'(bus.frame_done && !bus.win_valid), 64'(0));
    if (bus.win_valid === 1'b1) begin
      if (nwin == 0) first_win = bus.win_data;
      nwin++;
    end
    if (bus.frame_done === 1'b1) begin
      fd_win = bus.win_data;
      nfd++;
    end
  endtask

  task automatic do_reset(input logic v);
    rst_n = 1'b0;
    bus.in_valid = v;
    bus.in_data  = 4'hF;
    @(posedge clk);
    #1;
    chk("rst_win_valid", 64'(bus.win_valid), 64'(0));
    chk("rst_frame_done", 64'(bus.frame_done), 64'(0));
    chk("rst_win_row", 64'(bus.win_row), 64'(0));
    chk("rst_win_col", 64'(bus.win_col), 64'(0));
    chk("rst_win_data", 64'(bus.win_data), 64'(0));
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    mr = 0;
    mc = 0;
  endtask

  task automatic run_frame(input int off, input logic toggle);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 4'((i + off) % 16));
      if (toggle) step(1'b0, 4'($urandom));
    end
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_count"}, 64'(nwin), 64'(4));
    chk({tag, "_first"}, 64'(first_win), 64'(S1_FIRST));
    chk({tag, "_fd_count"}, 64'(nfd), 64'(1));
    chk({tag, "_fd_win"}, 64'(fd_win), 64'(S1_LAST));
  endtask

  initial begin
    logic v;
    int   acc;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    mr = 0;
    mc = 0;
    clr();
    @(posedge clk);
    #1;
    do_reset(1'b0);

    clr();
    run_frame(0, 1'b0);
    frame_checks("s1");

    clr();
    run_frame(0, 1'b1);
    frame_checks("s2");

    run_frame(0, 1'b0);
    clr();
    for (int i = 0; i < 10; i++) step(1'b1, 4'((i + 3) % 16));
    chk("f2_early", 64'(nwin), 64'(0));
    for (int i = 10; i < 16; i++) step(1'b1, 4'((i + 3) % 16));
    chk("f2_count", 64'(nwin), 64'(4));
    chk("f2_first", 64'(first_win), 64'(F2_FIRST));

    for (int i = 0; i < 10; i++) step(1'b1, 4'(i));
    do_reset(1'b0);
    clr();
    run_frame(0, 1'b0);
    frame_checks("s4");

    step(1'b1, 4'd7);
    step(1'b1, 4'd7);
    do_reset(1'b1);
    clr();
    run_frame(0, 1'b0);
    frame_checks("s5");

    clr();
    acc = 0;
    for (int n = 0; n < 2000 && acc < 3 * W * H; n++) begin
      v = ($urandom_range(0, 3) != 0);
      step(v, 4'($urandom));
      if (v) acc++;
    end
    chk("rnd_count", 64'(nwin), 64'(12));
    chk("rnd_fd_count", 64'(nfd), 64'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
